// File: rtl/exp4_fluxo_dados.sv
// Datapath for the Experiment 4 memory game: position counter, sequence ROM,
// play register, equality comparator and button rising-edge detector.
module exp4_fluxo_dados (
    input  logic       clock,
    input  logic       reset,
    input  logic       zeraC,
    input  logic       contaC,
    input  logic       zeraR,
    input  logic       registraR,
    input  logic [3:0] chaves,
    output logic       jogada,
    output logic       igual,
    output logic       fim,
    output logic [3:0] db_contagem,
    output logic [3:0] db_memoria,
    output logic [3:0] db_jogada,
    output logic       db_tem_jogada
);

    logic [3:0] contagem;
    logic [3:0] registro;
    logic [3:0] memoria;
    logic       tem_d;

    // Position counter: clear has priority over increment; wraps 15 -> 0.
    always_ff @(posedge clock) begin
        if (reset)
            contagem <= '0;
        else if (zeraC)
            contagem <= '0;
        else if (contaC)
            contagem <= contagem + 4'd1;
    end

    // Play register: clear has priority over load; raw button value is stored.
    always_ff @(posedge clock) begin
        if (reset)
            registro <= '0;
        else if (zeraR)
            registro <= '0;
        else if (registraR)
            registro <= chaves;
    end

    // Previous-cycle "any button" level; resets to 1 so a button held
    // across reset release is not reported as a fresh press.
    always_ff @(posedge clock) begin
        if (reset)
            tem_d <= 1'b1;
        else
            tem_d <= db_tem_jogada;
    end

    // Fixed 16-entry sequence ROM, asynchronous read at the counter position.
    always_comb begin
        memoria = 4'b0001;
        case (contagem)
            4'd0:  memoria = 4'b0001;
            4'd1:  memoria = 4'b0010;
            4'd2:  memoria = 4'b0100;
            4'd3:  memoria = 4'b1000;
            4'd4:  memoria = 4'b0100;
            4'd5:  memoria = 4'b0010;
            4'd6:  memoria = 4'b0001;
            4'd7:  memoria = 4'b0001;
            4'd8:  memoria = 4'b0010;
            4'd9:  memoria = 4'b0010;
            4'd10: memoria = 4'b0100;
            4'd11: memoria = 4'b0100;
            4'd12: memoria = 4'b1000;
            4'd13: memoria = 4'b1000;
            4'd14: memoria = 4'b0001;
            4'd15: memoria = 4'b0100;
            default: memoria = 4'b0001;
        endcase
    end

    // Status and debug outputs; the press pulse is suppressed while in reset.
    always_comb begin
        db_tem_jogada = |chaves;
        jogada        = db_tem_jogada & ~tem_d & ~reset;
        igual         = (registro == memoria);
        fim           = (contagem == 4'd15);
        db_contagem   = contagem;
        db_memoria    = memoria;
        db_jogada     = registro;
    end

endmodule

// File: tb/tb_exp4_fluxo_dados.sv
// Self-checking bench for exp4_fluxo_dados: a reference model pushes the
// expected outputs of each cycle to a scoreboard when stimulus is driven;
// each test task pops and compares them against the sampled DUT outputs.
module tb_exp4_fluxo_dados;

    logic       clock;
    logic       reset;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic [3:0] chaves;
    logic       jogada;
    logic       igual;
    logic       fim;
    logic [3:0] db_contagem;
    logic [3:0] db_memoria;
    logic [3:0] db_jogada;
    logic       db_tem_jogada;

    exp4_fluxo_dados dut (
        .clock         (clock),
        .reset         (reset),
        .zeraC         (zeraC),
        .contaC        (contaC),
        .zeraR         (zeraR),
        .registraR     (registraR),
        .chaves        (chaves),
        .jogada        (jogada),
        .igual         (igual),
        .fim           (fim),
        .db_contagem   (db_contagem),
        .db_memoria    (db_memoria),
        .db_jogada     (db_jogada),
        .db_tem_jogada (db_tem_jogada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       rst;
        logic       zc;
        logic       cc;
        logic       zr;
        logic       rr;
        logic [3:0] ch;
    } stim_t;

    typedef struct packed {
        logic [3:0] cnt;
        logic [3:0] mem;
        logic [3:0] jog;
        logic       fim;
        logic       igual;
        logic       jogada;
        logic       tem;
    } obs_t;

    logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                             4'b0100, 4'b0010, 4'b0001, 4'b0001,
                             4'b0010, 4'b0010, 4'b0100, 4'b0100,
                             4'b1000, 4'b1000, 4'b0001, 4'b0100};

    logic [3:0] m_cnt;
    logic [3:0] m_reg;
    logic       m_temd;
    stim_t      cur;
    obs_t       obs;
    obs_t       e;
    obs_t       sb[$];
    int         checks = 0;
    int         errors = 0;

    function automatic stim_t mk(input logic rst, input logic zc, input logic cc,
                                 input logic zr, input logic rr, input logic [3:0] ch);
        stim_t s;
        s.rst = rst; s.zc = zc; s.cc = cc; s.zr = zr; s.rr = rr; s.ch = ch;
        return s;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cnt = db_contagem; o.mem = db_memoria; o.jog = db_jogada;
        o.fim = fim; o.igual = igual; o.jogada = jogada; o.tem = db_tem_jogada;
        return o;
    endfunction

    // Drive one cycle of stimulus, push the model's expectation, sample at negedge.
    task automatic drive_cycle(input stim_t s);
        obs_t x;
        cur = s;
        reset = s.rst; zeraC = s.zc; contaC = s.cc;
        zeraR = s.zr; registraR = s.rr; chaves = s.ch;
        x.cnt    = m_cnt;
        x.mem    = rom[m_cnt];
        x.jog    = m_reg;
        x.fim    = (m_cnt == 4'd15);
        x.igual  = (m_reg == rom[m_cnt]);
        x.tem    = |s.ch;
        x.jogada = (|s.ch) & ~m_temd & ~s.rst;
        sb.push_back(x);
        @(negedge clock);
        obs = sample();
    endtask

    // Advance through the active edge and update the reference model.
    task automatic finish_cycle();
        @(posedge clock);
        #1;
        if (cur.rst) begin
            m_cnt = 4'd0; m_reg = 4'd0; m_temd = 1'b1;
        end else begin
            if (cur.zc)      m_cnt = 4'd0;
            else if (cur.cc) m_cnt = m_cnt + 4'd1;
            if (cur.zr)      m_reg = 4'd0;
            else if (cur.rr) m_reg = cur.ch;
            m_temd = |cur.ch;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; zeraC = 1'b0; contaC = 1'b0;
        zeraR = 1'b0; registraR = 1'b0; chaves = 4'b0000;
        repeat (2) @(posedge clock);
        #1;
        m_cnt = 4'd0; m_reg = 4'd0; m_temd = 1'b1;
        reset = 1'b0;
        cur = mk(0, 0, 0, 0, 0, 4'b0000);
        // first post-reset cycle against fixed values
        sb.push_back('{cnt: 4'd0, mem: 4'b0001, jog: 4'd0, fim: 1'b0,
                       igual: 1'b0, jogada: 1'b0, tem: 1'b0});
        @(negedge clock);
        obs = sample();
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs, e);
        end
        finish_cycle();
    endtask

    task automatic test_edge();
        stim_t st[$];
        int pulses_hold = 0;
        int pulses_swap = 0;
        int pulses_held_reset = 0;
        repeat (5) st.push_back(mk(0, 0, 0, 0, 0, 4'b0010));
        repeat (3) st.push_back(mk(0, 0, 0, 0, 0, 4'b0100));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 4'b1000));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 4'b0001));
        repeat (2) st.push_back(mk(1, 0, 0, 0, 0, 4'b0001));
        repeat (3) st.push_back(mk(0, 0, 0, 0, 0, 4'b0001));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        repeat (2) st.push_back(mk(0, 0, 0, 0, 0, 4'b0001));
        foreach (st[i]) begin
            drive_cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL edge cyc %0d: got %h expected %h", i, obs, e);
            end
            if (i < 5) pulses_hold += int'(obs.jogada);
            else if (i < 8) pulses_swap += int'(obs.jogada);
            else if (i >= 14 && i < 19) pulses_held_reset += int'(obs.jogada);
            finish_cycle();
        end
        checks++;
        if (pulses_hold != 1) begin
            errors++;
            $display("FAIL edge_hold_pulses: got %0d expected 1", pulses_hold);
        end
        checks++;
        if (pulses_swap != 0) begin
            errors++;
            $display("FAIL edge_swap_pulses: got %0d expected 0", pulses_swap);
        end
        checks++;
        if (pulses_held_reset != 0) begin
            errors++;
            $display("FAIL edge_held_reset_pulses: got %0d expected 0", pulses_held_reset);
        end
    endtask

    task automatic test_match();
        stim_t st[$];
        logic igual_hit = 1'b0;
        st.push_back(mk(0, 1, 0, 1, 0, 4'b0000));
        st.push_back(mk(0, 0, 0, 0, 1, 4'b0001));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0001));
        st.push_back(mk(0, 0, 0, 0, 1, 4'b0010));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        foreach (st[i]) begin
            drive_cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL match cyc %0d: got %h expected %h", i, obs, e);
            end
            if (i == 2) igual_hit = obs.igual;
            finish_cycle();
        end
        checks++;
        if (igual_hit !== 1'b1 || obs.igual !== 1'b0 || obs.jog !== 4'b0010) begin
            errors++;
            $display("FAIL match_fixed: got hit=%b igual=%b jog=%h expected 1 0 2",
                     igual_hit, obs.igual, obs.jog);
        end
    endtask

    task automatic test_walk();
        stim_t st[$];
        int fim_count = 0;
        int igual_count = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            st.push_back(mk(0, 0, 0, 0, 1, rom[i]));
            st.push_back(mk(0, 0, 1, 0, 0, 4'b0000));
        end
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        foreach (st[i]) begin
            drive_cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL walk cyc %0d: got %h expected %h", i, obs, e);
            end
            fim_count += int'(obs.fim);
            if (st[i].cc) igual_count += int'(obs.igual);
            finish_cycle();
        end
        checks++;
        if (fim_count != 2 || igual_count != 16) begin
            errors++;
            $display("FAIL walk_counts: got fim=%0d igual=%0d expected fim=2 igual=16",
                     fim_count, igual_count);
        end
        checks++;
        if (obs.cnt !== 4'd0 || obs.mem !== 4'b0001 || obs.fim !== 1'b0) begin
            errors++;
            $display("FAIL walk_wrap: got cnt=%h mem=%h fim=%b expected 0 1 0",
                     obs.cnt, obs.mem, obs.fim);
        end
    endtask

    task automatic test_priority();
        stim_t st[$];
        logic [3:0] cnt_before = 4'hx;
        st.push_back(mk(0, 1, 0, 0, 0, 4'b0000));
        repeat (5) st.push_back(mk(0, 0, 1, 0, 0, 4'b0000));
        st.push_back(mk(0, 1, 1, 0, 1, 4'b0100));
        st.push_back(mk(0, 0, 0, 1, 1, 4'b1000));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        foreach (st[i]) begin
            drive_cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL priority cyc %0d: got %h expected %h", i, obs, e);
            end
            if (i == 6) cnt_before = obs.cnt;
            finish_cycle();
        end
        checks++;
        if (cnt_before !== 4'd5 || obs.cnt !== 4'd0 || obs.jog !== 4'd0 || obs.igual !== 1'b0) begin
            errors++;
            $display("FAIL priority_fixed: got before=%h cnt=%h jog=%h igual=%b expected 5 0 0 0",
                     cnt_before, obs.cnt, obs.jog, obs.igual);
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        st.push_back(mk(0, 1, 0, 1, 0, 4'b0000));
        repeat (9) st.push_back(mk(0, 0, 1, 0, 0, 4'b0000));
        st.push_back(mk(0, 0, 0, 0, 1, 4'b0010));
        st.push_back(mk(1, 0, 1, 0, 1, 4'b0010));
        st.push_back(mk(0, 0, 0, 0, 0, 4'b0000));
        foreach (st[i]) begin
            drive_cycle(st[i]);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", i, obs, e);
            end
            finish_cycle();
        end
        checks++;
        if (obs.cnt !== 4'd0 || obs.jog !== 4'd0 || obs.mem !== 4'b0001 || obs.jogada !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fixed: got cnt=%h jog=%h mem=%h jogada=%b expected 0 0 1 0",
                     obs.cnt, obs.jog, obs.mem, obs.jogada);
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_match();
        test_walk();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exp4_fluxo_dados.md
# exp4_fluxo_dados

Datapath for the Experiment 4 memory game. It sits directly beneath the game's control unit and is the only consumer of that unit's `zeraC`, `contaC`, `zeraR` and `registraR` commands. It returns the `jogada`, `igual` and `fim` status signals. Internally it holds a 4-bit position counter, a fixed 16-entry sequence ROM, a 4-bit play register, an equality comparator and a rising-edge detector on the player buttons.

## Interface
- No parameters. Widths and ROM contents are fixed.
- `clock` — in, 1 — system clock; all state updates on its rising edge.
- `reset` — in, 1 — synchronous, active-high; overrides every other input.
- `zeraC` — in, 1 — clear the position counter.
- `contaC` — in, 1 — increment the position counter.
- `zeraR` — in, 1 — clear the play register.
- `registraR` — in, 1 — load `chaves` into the play register.
- `chaves` — in, 4 — player buttons, one-hot when a valid play is made.
- `jogada` — out, 1 — one-cycle pulse when any button is first pressed.
- `igual` — out, 1 — play register equals ROM[counter].
- `fim` — out, 1 — counter is at the last position (15).
- `db_contagem` — out, 4 — counter value.
- `db_memoria` — out, 4 — ROM[counter].
- `db_jogada` — out, 4 — play register contents.
- `db_tem_jogada` — out, 1 — level signal, OR of `chaves`.

## Operation
- **Counter (4-bit):**
  - Priority order: `reset` > `zeraC` > `contaC`.
  - `zeraC` loads 0. `contaC` adds 1, wrapping 15 → 0.
  - When neither is asserted, the counter holds.
- **ROM (16x4, asynchronous read, addressed by counter)**, addresses 0..15 hold: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100.
- **Play register (4-bit):**
  - Priority order: `reset` > `zeraR` > `registraR`.
  - `registraR` loads the raw `chaves` value; non-one-hot values are stored unchanged.
  - When neither is asserted, the register holds.
- **Comparator:** `igual` = (play register == ROM[counter]), combinational, full 4-bit compare.
  - A register value of 0000 never matches, because no ROM entry is 0000.
- **`fim`:** (counter == 15), combinational.
- **Edge detector:**
  - `db_tem_jogada` = |`chaves`, combinational.
  - One flop `tem_d` samples `db_tem_jogada` every cycle.
  - `jogada` = `db_tem_jogada` & ~`tem_d`, combinational.
  - Holding a button produces exactly one pulse. A pulse requires a release of at least one cycle followed by a new press.
  - Changing which button is held without ever reaching all-zero produces no new pulse.
- **Reset values:**
  - Counter = 0, register = 0, `tem_d` = 1.
  - Resulting outputs: `fim`=0, `igual`=0, `db_memoria`=0001, `db_jogada`=0000, `db_contagem`=0000.
  - `jogada`=0 during reset and in the first cycle after reset, even if a button is held through reset. A button held across reset release produces no pulse until it is released and pressed again.

## Timing
- **Counter and register latency:** a command sampled at edge k takes effect in the cycle after edge k.
- **Comparator path:**
  - `registraR` high in cycle n → register updated at the end of cycle n.
  - `igual` is valid in cycle n+1, matching the control unit's registra → comparacao sequence.
- **Counter path:** `contaC` high in cycle n → counter, `db_memoria`, `fim` and `igual` all reflect the new position in cycle n+1.
- **`jogada` timing:**
  - `jogada` rises in the same cycle that `chaves` first becomes nonzero (no register delay).
  - It falls after one clock edge regardless of `chaves`.
  - The control unit samples it on the next edge.
- **Simultaneous commands:**
  - `zeraC`+`contaC` → counter 0.
  - `zeraR`+`registraR` → register 0.
  - Counter and register commands are independent of each other and may be asserted together.
- **Reset mid-game:** clears the counter and register on the next edge regardless of pending commands, and forces `tem_d`=1.
- **Wrap:** `contaC` at counter 15 → counter 0, `fim` drops to 0, `db_memoria`=0001.

## Test plan
1. **Reset values:** assert `reset` 2 cycles with `chaves`=0000, then release. Require `db_contagem`=0, `db_jogada`=0, `db_memoria`=0001, `fim`=0, `igual`=0 and `jogada`=0 in the first post-reset cycle.
2. **Edge detector:**
   - Press `chaves`=0010 and hold it 5 cycles → `jogada`=1 for exactly one cycle.
   - Without releasing, change to 0100 → no pulse.
   - Release 1 cycle, press 1000 → one new pulse.
   - Hold 0001 through reset and release reset with it still held → no pulse until release and re-press.
3. **Match path:** counter at 0, `chaves`=0001, pulse `registraR` → `db_jogada`=0001 and `igual`=1 the next cycle. Then `chaves`=0010 with `registraR` → `igual`=0.
4. **Full walk:**
   - For each position i = 0..15, load ROM[i] via `registraR`, check `igual`=1, then pulse `contaC`.
   - `fim`=1 only at i=15.
   - The 16th `contaC` wraps to 0 with `db_memoria`=0001.
5. **Priority:**
   - Counter at 5: assert `zeraC`+`contaC` → counter 0.
   - Register at 0100: assert `zeraR`+`registraR` with `chaves`=1000 → register 0000, `igual`=0.
6. **Reset mid-operation:** counter at 9, register 0010, `registraR` and `contaC` high alongside a one-cycle `reset` → counter 0, register 0 next cycle, `db_memoria`=0001.
